// File: rtl/uart_bfm_ahbl_slave.sv
// AHB-Lite responder BFM: word-organised RAM with byte/half/word access,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
`timescale 1ns/1ps
module uart_bfm_ahbl_slave #(
  parameter int MEM_AW      = 10,
  parameter int WINDOW_AW   = 20,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] ERR_COUNT
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  localparam logic [3:0] WS_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW+1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                write_q, write_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic [31:0]         mem [0:(1<<MEM_AW)-1];
  logic                accept, acc_err, mem_we;
  logic [3:0]          be;

  logic unused_in;
  assign unused_in = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:WINDOW_AW+1]};

  // The bit just above the window is included so an access that wraps past the
  // decoded window is answered with ERROR rather than aliasing into the RAM.
  always_comb begin
    accept  = HSEL & HREADY & HTRANS[1] & ((state_q == S_IDLE) | (state_q == S_LAST));
    acc_err = (HSIZE > 3'd2)
            | ((HSIZE == 3'd1) & HADDR[0])
            | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
            | (HADDR[WINDOW_AW:MEM_AW+2] != '0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    write_d   = write_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE, S_LAST: begin
        if (accept) begin
          addr_d  = HADDR[MEM_AW+1:0];
          size_d  = HSIZE[1:0];
          write_d = HWRITE;
          cnt_d   = WS_RELOAD;
          if (acc_err)              state_d = S_ERR1;
          else if (WAIT_STATES > 0) state_d = S_WAIT;
          else                      state_d = S_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      S_ERR2: begin
        state_d = S_IDLE;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      size_q    <= 2'd0;
      write_q   <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      write_q   <= write_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Little-endian lane enables; only the addressed lanes of the word change.
  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    mem_we = (state_q == S_LAST) & write_q;
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[MEM_AW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = ((state_q == S_LAST) && !write_q) ? mem[addr_q[MEM_AW+1:2]] : 32'h0;
  assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_uart_bfm_ahbl_slave.sv
// Directed bench for uart_bfm_ahbl_slave: one zero-wait instance and one
// three-wait-state instance share the address/data bus.
`timescale 1ns/1ps
module tb_uart_bfm_ahbl_slave;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready0, hreadyout0, hresp0;
  logic        hready1, hreadyout1, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic [15:0] err_count0, err_count1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign hready0 = hreadyout0;
  assign hready1 = hreadyout1;

  uart_bfm_ahbl_slave #(.MEM_AW(10), .WINDOW_AW(20), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(hready0), .HREADYOUT(hreadyout0), .HRESP(hresp0),
    .HRDATA(hrdata0), .ERR_COUNT(err_count0)
  );

  uart_bfm_ahbl_slave #(.MEM_AW(10), .WINDOW_AW(20), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(hready1), .HREADYOUT(hreadyout1), .HRESP(hresp1),
    .HRDATA(hrdata1), .ERR_COUNT(err_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic s0, input logic s1, input logic [31:0] a,
                         input logic w, input logic [2:0] sz);
    hsel0 = s0; hsel1 = s1; haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_ph(1'b1, 1'b0, a, 1'b1, sz);
    @(negedge clk);
    bus_idle(); hwdata = d;
    @(negedge clk);
  endtask

  task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_ph(1'b1, 1'b0, a, 1'b0, 3'd2);
    @(negedge clk);
    bus_idle();
    chk({tag, "_rdy"}, {31'd0, hreadyout0}, 32'd1);
    chk(tag, hrdata0, exp);
    @(negedge clk);
  endtask

  task automatic err0(input string tag, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] d);
    addr_ph(1'b1, 1'b0, a, w, sz);
    @(negedge clk);
    bus_idle(); hwdata = d;
    chk({tag, "_err1"}, {30'd0, hreadyout0, hresp0}, 32'b01);
    @(negedge clk);
    chk({tag, "_err2"}, {30'd0, hreadyout0, hresp0}, 32'b11);
    @(negedge clk);
  endtask

  task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_ph(1'b0, 1'b1, a, 1'b0, 3'd2);
    @(negedge clk);
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_wait"}, {31'd0, hreadyout1}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_rdy"}, {31'd0, hreadyout1}, 32'd1);
    chk(tag, hrdata1, exp);
    @(negedge clk);
    chk({tag, "_after"}, hrdata1, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    hreset = 1'b1; hwdata = 32'h0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
    bus_idle();
    repeat (2) @(negedge clk);
    chk("rst_hreadyout", {31'd0, hreadyout0}, 32'd1);
    chk("rst_hresp",     {31'd0, hresp0},     32'd0);
    chk("rst_hrdata",    hrdata0,             32'h0);
    chk("rst_errcnt",    {16'd0, err_count0}, 32'd0);
    hreset = 1'b0;
    @(negedge clk);

    wr0(32'h10, 3'd2, 32'hDEADBEEF);
    rd0("word_rd", 32'h10, 32'hDEADBEEF);
    chk("idle_hrdata", hrdata0, 32'h0);

    wr0(32'h10, 3'd2, 32'h11223344);
    wr0(32'h13, 3'd0, 32'hAA000000);
    rd0("byte_wr", 32'h10, 32'hAA223344);
    wr0(32'h12, 3'd1, 32'h55660000);
    rd0("half_wr", 32'h10, 32'h55663344);

    addr_ph(1'b1, 1'b0, 32'h20, 1'b1, 3'd2);
    @(negedge clk);
    addr_ph(1'b1, 1'b0, 32'h20, 1'b0, 3'd2);
    hwdata = 32'h00000001;
    chk("b2b_wr_rdy", {31'd0, hreadyout0}, 32'd1);
    @(negedge clk);
    bus_idle();
    chk("b2b_rd", hrdata0, 32'h00000001);
    @(negedge clk);

    err0("oow_rd", 32'h00100000, 1'b0, 3'd2, 32'h0);
    chk("errcnt_1", {16'd0, err_count0}, 32'd1);
    err0("beyond_ram", 32'h00001000, 1'b0, 3'd2, 32'h0);
    err0("misalign_w", 32'h00000002, 1'b0, 3'd2, 32'h0);
    err0("size3_wr", 32'h00000010, 1'b1, 3'd3, 32'hFFFFFFFF);
    err0("misalign_h", 32'h00000011, 1'b1, 3'd1, 32'hFFFFFFFF);
    chk("errcnt_5", {16'd0, err_count0}, 32'd5);
    rd0("ram_kept", 32'h10, 32'h55663344);

    addr_ph(1'b0, 1'b1, 32'h4, 1'b1, 3'd2);
    @(negedge clk);
    bus_idle(); hwdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      chk("ws_wr_wait", {31'd0, hreadyout1}, 32'd0);
      @(negedge clk);
    end
    chk("ws_wr_rdy", {31'd0, hreadyout1}, 32'd1);
    @(negedge clk);
    rd1("ws_rd", 32'h4, 32'h12345678);

    addr_ph(1'b0, 1'b1, 32'h4, 1'b1, 3'd2);
    @(negedge clk);
    bus_idle(); hwdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("pre_rst_wait", {31'd0, hreadyout1}, 32'd0);
    #1 hreset = 1'b1;
    #1;
    chk("async_rst_rdy",  {31'd0, hreadyout1}, 32'd1);
    chk("async_rst_resp", {31'd0, hresp1},     32'd0);
    chk("async_rst_cnt",  {16'd0, err_count0}, 32'd0);
    @(negedge clk);
    hreset = 1'b0;
    @(negedge clk);
    rd1("abort_no_wr", 32'h4, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
